// File: rtl/inst_queue.sv
// Circular instruction queue between ifetch and the decoder (depth 2**IQ_DEPTH_BIT).
// Optional same-cycle fetch-to-decode bypass on an empty queue: define IQ_BYPASS_EN.
module inst_queue #(
  parameter int IQ_DEPTH_BIT = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    fetch_valid,
  input  logic [31:0]             fetch_pc,
  input  logic [31:0]             fetch_inst,
  input  logic                    fetch_predict,
  output logic                    iq_full,
  output logic                    dec_valid,
  output logic [31:0]             dec_pc,
  output logic [31:0]             dec_inst,
  output logic                    dec_predict,
  input  logic                    dec_accept,
  input  logic                    flush,
  output logic [IQ_DEPTH_BIT:0]   iq_count
);

  localparam int DEPTH = 1 << IQ_DEPTH_BIT;
  localparam logic [IQ_DEPTH_BIT:0] FULL_CNT = (IQ_DEPTH_BIT + 1)'(DEPTH);

  // Handshakes: an entry enters on a cycle with fetch_valid && !iq_full, and the head
  // leaves on a cycle with dec_valid && dec_accept; neither happens while rdy_in is low
  // or when flush is high (flush empties the queue instead).

  logic [31:0]             pc_q      [DEPTH];
  logic [31:0]             inst_q    [DEPTH];
  logic                    predict_q [DEPTH];
  logic [IQ_DEPTH_BIT-1:0] head_q;
  logic [IQ_DEPTH_BIT-1:0] tail_q;
  logic [IQ_DEPTH_BIT:0]   count_q;

  logic stored_valid;
  logic push;
  logic pop;

  assign stored_valid = (count_q != '0);
  assign iq_full      = (count_q == FULL_CNT);
  assign iq_count     = count_q;

`ifdef IQ_BYPASS_EN
  logic bypass;
  logic bypass_take;

  // An empty queue forwards the fetch straight to the decoder; if the decoder takes it,
  // the instruction never lands in storage.
  assign bypass      = !stored_valid && fetch_valid && !flush;
  assign bypass_take = bypass && dec_accept;
  assign push        = fetch_valid && !iq_full && !bypass_take;
  assign pop         = dec_accept && stored_valid;
  assign dec_valid   = stored_valid || bypass;

  always_comb begin
    dec_pc      = '0;
    dec_inst    = '0;
    dec_predict = 1'b0;
    if (stored_valid) begin
      dec_pc      = pc_q[head_q];
      dec_inst    = inst_q[head_q];
      dec_predict = predict_q[head_q];
    end else if (bypass) begin
      dec_pc      = fetch_pc;
      dec_inst    = fetch_inst;
      dec_predict = fetch_predict;
    end
  end
`else
  assign push      = fetch_valid && !iq_full;
  assign pop       = dec_accept && stored_valid;
  assign dec_valid = stored_valid;

  always_comb begin
    dec_pc      = '0;
    dec_inst    = '0;
    dec_predict = 1'b0;
    if (stored_valid) begin
      dec_pc      = pc_q[head_q];
      dec_inst    = inst_q[head_q];
      dec_predict = predict_q[head_q];
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + 1'b1;
        if (pop)  head_q <= head_q + 1'b1;
        count_q <= count_q + {{IQ_DEPTH_BIT{1'b0}}, push} - {{IQ_DEPTH_BIT{1'b0}}, pop};
      end
    end
  end

  // Storage carries no reset; contents are only observed through a valid head.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !flush && push) begin
      pc_q[tail_q]      <= fetch_pc;
      inst_q[tail_q]    <= fetch_inst;
      predict_q[tail_q] <= fetch_predict;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (default build, no bypass); a queue holds the expected pcs.
module tb_inst_queue;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        fetch_predict;
  logic        iq_full;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic        dec_predict;
  logic        dec_accept;
  logic        flush;
  logic [3:0]  iq_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  inst_queue #(.IQ_DEPTH_BIT(3)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_inst    (fetch_inst),
    .fetch_predict (fetch_predict),
    .iq_full       (iq_full),
    .dec_valid     (dec_valid),
    .dec_pc        (dec_pc),
    .dec_inst      (dec_inst),
    .dec_predict   (dec_predict),
    .dec_accept    (dec_accept),
    .flush         (flush),
    .iq_count      (iq_count)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic push_one(input logic [31:0] pc);
    fetch_valid   = 1'b1;
    fetch_pc      = pc;
    fetch_inst    = 32'h0001_0013 | (pc << 12);
    fetch_predict = pc[2];
    dec_accept    = 1'b0;
    tick();
    fetch_valid   = 1'b0;
    exp_q.push_back(pc);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] pc;
    pc = exp_q.pop_front();
    check({tag, "_valid"}, {31'd0, dec_valid}, 32'd1);
    check({tag, "_pc"}, dec_pc, pc);
    check({tag, "_inst"}, dec_inst, 32'h0001_0013 | (pc << 12));
    check({tag, "_pred"}, {31'd0, dec_predict}, {31'd0, pc[2]});
    dec_accept = 1'b1;
    tick();
    dec_accept = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; fetch_valid = 1'b0; fetch_pc = '0;
    fetch_inst = '0; fetch_predict = 1'b0; dec_accept = 1'b0; flush = 1'b0;
    tick(); tick();
    check("rst_count", {28'd0, iq_count}, 32'd0);
    check("rst_valid", {31'd0, dec_valid}, 32'd0);
    check("rst_full",  {31'd0, iq_full}, 32'd0);
    check("rst_pc",    dec_pc, 32'd0);
    check("rst_inst",  dec_inst, 32'd0);
    check("rst_pred",  {31'd0, dec_predict}, 32'd0);
    rst_in = 1'b0;

    // single push visible after one cycle
    fetch_valid = 1'b1; fetch_pc = 32'h0; fetch_inst = 32'h0010_0093; fetch_predict = 1'b0;
    tick();
    fetch_valid = 1'b0;
    check("t1_valid", {31'd0, dec_valid}, 32'd1);
    check("t1_pc",    dec_pc, 32'h0);
    check("t1_inst",  dec_inst, 32'h0010_0093);
    check("t1_count", {28'd0, iq_count}, 32'd1);
    dec_accept = 1'b1; tick(); dec_accept = 1'b0;
    check("t1_drain", {28'd0, iq_count}, 32'd0);
    dec_accept = 1'b1; tick(); dec_accept = 1'b0;
    check("empty_accept_ignored", {28'd0, iq_count}, 32'd0);

    // fill to full, ninth push refused
    for (int i = 0; i < 8; i++) push_one(32'(i * 4));
    check("t2_full",  {31'd0, iq_full}, 32'd1);
    check("t2_count", {28'd0, iq_count}, 32'd8);
    fetch_valid = 1'b1; fetch_pc = 32'h20; tick(); fetch_valid = 1'b0;
    check("t2_refuse_count", {28'd0, iq_count}, 32'd8);
    check("t2_refuse_head",  dec_pc, 32'h0);

    // full with push and pop together: only the pop happens
    fetch_valid = 1'b1; fetch_pc = 32'h20; dec_accept = 1'b1;
    tick();
    fetch_valid = 1'b0; dec_accept = 1'b0;
    void'(exp_q.pop_front());
    check("t3_count", {28'd0, iq_count}, 32'd7);
    check("t3_head",  dec_pc, 32'h4);
    check("t3_full",  {31'd0, iq_full}, 32'd0);
    for (int i = 1; i < 8; i++) pop_check("t2_order");
    check("t3_no_0x20", {31'd0, dec_valid}, 32'd0);

    // alternate pushes and pops across the pointer wrap
    for (int i = 0; i < 5; i++) push_one(32'h200 + 32'(i * 4));
    for (int k = 0; k < 6; k++) begin
      push_one(32'h214 + 32'(k * 4));
      check("t4_count_hi", {28'd0, iq_count}, 32'(exp_q.size()));
      pop_check("t4_wrap");
      check("t4_count_lo", {28'd0, iq_count}, 32'(exp_q.size()));
    end
    pop_check("t4_trim");
    check("t5_pre_count", {28'd0, iq_count}, 32'd4);

    // flush beats concurrent push and pop
    flush = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h300; dec_accept = 1'b1;
    tick();
    flush = 1'b0; fetch_valid = 1'b0; dec_accept = 1'b0;
    exp_q.delete();
    check("t5_count", {28'd0, iq_count}, 32'd0);
    check("t5_valid", {31'd0, dec_valid}, 32'd0);
    check("t5_pc",    dec_pc, 32'd0);
    push_one(32'h100);
    check("t5_head", dec_pc, 32'h100);

    // stall holds everything; reset still wins under stall
    push_one(32'h104);
    push_one(32'h108);
    rdy_in = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'h400; dec_accept = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_hold_count", {28'd0, iq_count}, 32'd3);
      check("t6_hold_pc",    dec_pc, 32'h100);
    end
    fetch_valid = 1'b0; dec_accept = 1'b0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0; rdy_in = 1'b1;
    check("t6_rst_count", {28'd0, iq_count}, 32'd0);
    check("t6_rst_valid", {31'd0, dec_valid}, 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
